// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: maps a signed control word to a pulse width and emits
// one pulse per frame, with commands double-buffered to frame boundaries.
module servo_pwm_gen #(
  parameter int N         = 12,
  parameter int CW        = 20,
  parameter int FRAME_CYC = 1000000,
  parameter int PW_MIN    = 50000,
  parameter int PW_MAX    = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic signed [N-1:0]  cmd,
  input  logic                 cmd_valid,
  output logic                 pwm_out,
  output logic                 frame_start,
  output logic [CW-1:0]        width_cur
);

  localparam int PW_CENTER = (PW_MIN + PW_MAX) / 2;
  localparam int HALF      = (PW_MAX - PW_MIN) / 2;
  localparam int PW        = N + CW + 1;

  localparam logic [CW-1:0]        CENTER_W = CW'(PW_CENTER);
  localparam logic [CW-1:0]        LAST_IDX = CW'(FRAME_CYC - 1);
  localparam logic [CW-1:0]        CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] HALF_S   = PW'(HALF);
  localparam logic signed [PW-1:0] CENTER_S = PW'(PW_CENTER);

  localparam logic signed [N-1:0] CMD_MIN    = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [N-1:0] CMD_SATMIN = {1'b1, {(N-2){1'b0}}, 1'b1};

  // Fold the most negative code onto SatMin so the mapping is symmetric.
  function automatic logic signed [N-1:0] sat_cmd(input logic signed [N-1:0] c);
    if (c == CMD_MIN)
      return CMD_SATMIN;
    else
      return c;
  endfunction

  function automatic logic [CW-1:0] map_width(input logic signed [N-1:0] c);
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;
    logic signed [PW-1:0] sum;
    prod    = PW'(c) * HALF_S;
    shifted = prod >>> (N - 1);
    sum     = shifted + CENTER_S;
    return sum[CW-1:0];
  endfunction

  logic signed [N-1:0] r_cmd_p0;
  logic                r_vld_p0;
  logic [CW-1:0]       r_pend;
  logic [CW-1:0]       r_active;
  logic [CW-1:0]       r_cnt;
  logic                w_run;

  // Stage p0: capture the clamped command
  always_ff @(posedge clk) begin
    if (cmd_valid)
      r_cmd_p0 <= sat_cmd(cmd);
  end

  // Stage p1: scaled width lands in the pending buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0 <= 1'b0;
      r_pend   <= CENTER_W;
    end else begin
      r_vld_p0 <= cmd_valid;
      if (r_vld_p0)
        r_pend <= map_width(r_cmd_p0);
    end
  end

  // While disabled the active width tracks pending, so the first enabled
  // cycle already starts a frame with the latest buffered command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_active <= CENTER_W;
    end else if (!en || (r_cnt == LAST_IDX)) begin
      r_cnt    <= '0;
      r_active <= r_pend;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  // Outputs are gated by en and rst_n so disable or reset cuts a pulse at once.
  assign w_run       = rst_n & en;
  assign frame_start = w_run & (r_cnt == '0);
  assign pwm_out     = w_run & (r_cnt < r_active);
  assign width_cur   = r_active;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: a frame-level reference model checked
// every cycle, plus directed frames with hand-computed pulse widths.
module tb_servo_pwm_gen;

  localparam int N      = 12;
  localparam int CW     = 8;
  localparam int FRAME  = 100;
  localparam int PWMIN  = 20;
  localparam int PWMAX  = 40;
  localparam int CENTER = (PWMIN + PWMAX) / 2;
  localparam int HALF   = (PWMAX - PWMIN) / 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                en;
  logic signed [N-1:0] cmd;
  logic                cmd_valid;
  logic                pwm_out;
  logic                frame_start;
  logic [CW-1:0]       width_cur;

  int n_checks = 0;
  int n_fail   = 0;

  servo_pwm_gen #(
    .N(N), .CW(CW), .FRAME_CYC(FRAME), .PW_MIN(PWMIN), .PW_MAX(PWMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd), .cmd_valid(cmd_valid),
    .pwm_out(pwm_out), .frame_start(frame_start), .width_cur(width_cur)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pulse width from the command with plain integer math and explicit floor.
  function automatic int ref_width(input int c);
    int cc, p, q;
    cc = (c == -(1 << (N-1))) ? -((1 << (N-1)) - 1) : c;
    p  = cc * HALF;
    q  = p / (1 << (N-1));
    if ((p < 0) && ((p % (1 << (N-1))) != 0))
      q = q - 1;
    return CENTER + q;
  endfunction

  typedef struct {
    int due;
    int w;
  } upd_t;

  int   m_idx     = 0;
  int   m_active  = CENTER;
  int   m_pending = CENTER;
  int   m_cyc     = 0;
  upd_t m_q[$];

  always @(negedge clk) begin : model_cmp
    logic run;
    upd_t u;
    int   c;
    if (!rst_n) begin
      m_idx     = 0;
      m_active  = CENTER;
      m_pending = CENTER;
      m_q.delete();
    end
    run = rst_n && en;
    check("model frame_start", frame_start, (run && (m_idx == 0)));
    check("model pwm_out", pwm_out, (run && (m_idx < m_active)));
    check("model width_cur", width_cur, m_active);
    if (rst_n) begin
      if (!en || (m_idx == FRAME - 1)) begin
        m_idx    = 0;
        m_active = m_pending;
      end else begin
        m_idx++;
      end
      while ((m_q.size() > 0) && (m_q[0].due <= m_cyc)) begin
        m_pending = m_q[0].w;
        void'(m_q.pop_front());
      end
      if (cmd_valid) begin
        c     = cmd;
        u.due = m_cyc + 1;
        u.w   = ref_width(c);
        m_q.push_back(u);
      end
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full enabled frame starting at index 0, optionally issuing up to
  // two commands, and checks the pulse length against a literal.
  task automatic run_frame(input int exp_w, input int ia, input int ca, input int ib, input int cb);
    int hi;
    int fs;
    hi = 0;
    fs = 0;
    for (int i = 0; i < FRAME; i++) begin
      cmd_valid = (i == ia) || (i == ib);
      if (i == ia) cmd = ca[N-1:0];
      if (i == ib) cmd = cb[N-1:0];
      #1;
      if (pwm_out === 1'b1) hi++;
      if (frame_start === 1'b1) fs++;
      if (i == 0) check("width_cur at frame start", width_cur, exp_w);
      tick();
    end
    cmd_valid = 1'b0;
    check("pulse width", hi, exp_w);
    check("frame_start per frame", fs, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    cmd       = '0;
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("reset pwm_out", pwm_out, 0);
    check("reset frame_start", frame_start, 0);
    check("reset width_cur", width_cur, 30);
    en = 1'b1;
    #1;
    check("reset holds pwm_out low", pwm_out, 0);
    check("reset holds frame_start low", frame_start, 0);
    tick();
    rst_n = 1'b1;

    run_frame(30, -1, 0, -1, 0);
    run_frame(30, -1, 0, -1, 0);

    run_frame(30, 50, 2047, -1, 0);
    run_frame(39, 50, 1024, -1, 0);
    run_frame(35, 50, 0, -1, 0);
    run_frame(30, 50, -2047, -1, 0);
    run_frame(20, 50, -2048, -1, 0);
    run_frame(20, 50, 0, -1, 0);

    run_frame(30, 50, 2047, 60, -2047);
    run_frame(20, 98, 2047, -1, 0);
    run_frame(20, -1, 0, -1, 0);
    run_frame(39, 97, 1024, -1, 0);
    run_frame(35, 50, 0, -1, 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 9) begin
        #1;
        check("pwm high before en drop", pwm_out, 1);
      end
      tick();
    end
    en = 1'b0;
    #1;
    check("pwm drops with en", pwm_out, 0);
    check("no frame_start while disabled", frame_start, 0);
    repeat (7) tick();
    en = 1'b1;
    run_frame(30, -1, 0, -1, 0);

    run_frame(30, 50, 2047, -1, 0);
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        #1;
        check("pwm high before reset", pwm_out, 1);
        check("width 39 before reset", width_cur, 39);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    check("pwm drops on reset", pwm_out, 0);
    check("frame_start low in reset", frame_start, 0);
    check("width_cur back to center", width_cur, 30);
    tick();
    tick();
    rst_n = 1'b1;
    run_frame(30, -1, 0, -1, 0);
    run_frame(30, -1, 0, -1, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
